// File: rtl/video_sync_decoder.sv
// Recovers pixel coordinates from external hsync/vsync/active timing, measures
// line/frame geometry, and runs a lock FSM that flags timing faults.
module video_sync_decoder #(
  parameter int H_ACTIVE    = 800,
  parameter int H_TOTAL     = 1056,
  parameter int V_ACTIVE    = 600,
  parameter int V_TOTAL     = 628,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        active,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        pixel_valid,
  output logic        line_start,
  output logic        frame_start,
  output logic [10:0] h_total_meas,
  output logic [9:0]  v_total_meas,
  output logic        locked,
  output logic        timing_err
);

  // state   | meaning
  // SEARCH  | waiting for a vsync fall to start measuring; faults ignored
  // MEASURE | counting consecutive good frames toward lock
  // LOCKED  | timing matches parameters; checks continue every line/frame
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state, state_next;
  logic        hs_s1, hs_s2, vs_s1, vs_s2, act_s1, act_s2;
  logic [10:0] h_cnt;
  logic [9:0]  line_cnt;
  logic        first_line;
  logic        skip_h, skip_next;
  logic [7:0]  good_frames, gf_next;
  logic        err_next;

  logic        hs_fall, vs_fall, act_rise, act_fall;
  logic [10:0] h_period;
  logic [9:0]  line_cnt_inc, lines_in_frame;
  logic        h_fault, sat_fault, x_fault, y_fault, v_fault, fault, frame_ok;

  assign hs_fall  = hs_s2 & ~hs_s1;
  assign vs_fall  = vs_s2 & ~vs_s1;
  assign act_rise = act_s1 & ~act_s2;
  assign act_fall = ~act_s1 & act_s2;

  assign h_period       = (h_cnt == 11'h7FF) ? h_cnt : h_cnt + 11'd1;
  assign line_cnt_inc   = (line_cnt == 10'h3FF) ? line_cnt : line_cnt + 10'd1;
  // a line ending on the same clock as the frame still belongs to that frame
  assign lines_in_frame = hs_fall ? line_cnt_inc : line_cnt;

  assign h_fault   = hs_fall && !skip_h && (h_period != 11'(H_TOTAL));
  assign sat_fault = !hs_fall && (h_cnt == 11'h7FE);
  assign x_fault   = act_fall && (pixel_x != 10'(H_ACTIVE - 1));
  assign y_fault   = act_rise && !first_line &&
                     (({1'b0, pixel_y} + 11'd1) >= 11'(V_ACTIVE));
  assign v_fault   = vs_fall && (lines_in_frame != 10'(V_TOTAL));
  assign fault     = h_fault | sat_fault | x_fault | y_fault | v_fault;
  assign frame_ok  = vs_fall && !v_fault;

  always_comb begin
    state_next = state;
    gf_next    = good_frames;
    skip_next  = hs_fall ? 1'b0 : skip_h;
    err_next   = 1'b0;
    case (state)
      SEARCH: begin
        if (vs_fall) begin
          state_next = MEASURE;
          gf_next    = 8'd0;
          skip_next  = 1'b1;
        end
      end
      MEASURE: begin
        if (fault) begin
          state_next = SEARCH;
          gf_next    = 8'd0;
          err_next   = 1'b1;
        end else if (frame_ok) begin
          gf_next = good_frames + 8'd1;
          if (gf_next >= 8'(LOCK_FRAMES)) state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (fault) begin
          state_next = SEARCH;
          gf_next    = 8'd0;
          err_next   = 1'b1;
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SEARCH;
      good_frames  <= 8'd0;
      skip_h       <= 1'b0;
      timing_err   <= 1'b0;
      hs_s1        <= 1'b1;
      hs_s2        <= 1'b1;
      vs_s1        <= 1'b1;
      vs_s2        <= 1'b1;
      act_s1       <= 1'b0;
      act_s2       <= 1'b0;
      h_cnt        <= 11'd0;
      line_cnt     <= 10'd0;
      first_line   <= 1'b0;
      h_total_meas <= 11'd0;
      v_total_meas <= 10'd0;
      pixel_x      <= 10'd0;
      pixel_y      <= 10'd0;
      pixel_valid  <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      state       <= state_next;
      good_frames <= gf_next;
      skip_h      <= skip_next;
      timing_err  <= err_next;
      hs_s1       <= hsync;
      hs_s2       <= hs_s1;
      vs_s1       <= vsync;
      vs_s2       <= vs_s1;
      act_s1      <= active;
      act_s2      <= act_s1;

      if (hs_fall) begin
        h_cnt        <= 11'd0;
        h_total_meas <= h_period;
      end else if (h_cnt != 11'h7FF) begin
        h_cnt <= h_cnt + 11'd1;
      end

      if (vs_fall) begin
        line_cnt     <= 10'd0;
        v_total_meas <= lines_in_frame;
      end else if (hs_fall) begin
        line_cnt <= line_cnt_inc;
      end

      if (vs_fall) first_line <= 1'b1;
      else if (act_rise) first_line <= 1'b0;

      if (act_rise) begin
        pixel_x <= 10'd0;
        pixel_y <= first_line ? 10'd0 : pixel_y + 10'd1;
      end else if (act_s1 && act_s2) begin
        pixel_x <= pixel_x + 10'd1;
      end

      pixel_valid <= act_s1;
      line_start  <= act_rise;
      frame_start <= act_rise & first_line;
    end
  end

endmodule

// File: tb/tb_video_sync_decoder.sv
// Bench for video_sync_decoder using a scaled-down 8x6 (16x10 total) raster so
// full frames, lock, relock and fault recovery fit in a few thousand clocks.
module tb_video_sync_decoder;

  localparam int HA = 8;
  localparam int HT = 16;
  localparam int VA = 6;
  localparam int VT = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic        active = 1'b0;
  logic [9:0]  pixel_x, pixel_y;
  logic        pixel_valid, line_start, frame_start, locked, timing_err;
  logic [10:0] h_total_meas;
  logic [9:0]  v_total_meas;

  video_sync_decoder #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .active(active),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .line_start(line_start), .frame_start(frame_start),
    .h_total_meas(h_total_meas), .v_total_meas(v_total_meas),
    .locked(locked), .timing_err(timing_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Independent pipeline model: outputs must mirror inputs seen two cycles earlier.
  int err_cnt = 0, fs_cnt = 0, ls_in_frame = 0, last_x = 0, last_y = 0, lat_bad = 0;
  bit a1, a2, a3, v1 = 1, v2 = 1, v3 = 1, fl;
  always @(negedge clk) begin
    if (!rst_n) begin
      a1 = 0; a2 = 0; a3 = 0; v1 = 1; v2 = 1; v3 = 1; fl = 0;
    end else begin
      bit exp_ls, exp_fs;
      exp_ls = a2 & ~a3;
      exp_fs = exp_ls & fl;
      if (pixel_valid != a2) lat_bad++;
      if (line_start != exp_ls) lat_bad++;
      if (frame_start != exp_fs) lat_bad++;
      if (line_start && pixel_x != 0) lat_bad++;
      if (frame_start && pixel_y != 0) lat_bad++;
      if (exp_ls) fl = 0;
      if (!v2 && v3) fl = 1;
      if (timing_err) err_cnt++;
      if (frame_start) begin fs_cnt++; ls_in_frame = 1; end
      else if (line_start) ls_in_frame++;
      if (pixel_valid) begin last_x = pixel_x; last_y = pixel_y; end
      a3 = a2; a2 = a1; a1 = active;
      v3 = v2; v2 = v1; v1 = vsync;
    end
  end

  task automatic drive_line(input int len, input int act_len, input bit vs_lo, input bit has_act);
    for (int c = 0; c < len; c++) begin
      @(posedge clk); #1;
      hsync  = !(c < 2);
      vsync  = !vs_lo;
      active = has_act && (c >= 4) && (c < 4 + act_len);
    end
  endtask

  task automatic drive_lines(input int lo, input int hi, input int long_line,
                             input int short_line, input int n_act);
    for (int l = lo; l <= hi; l++)
      drive_line((l == long_line) ? HT + 1 : HT, (l == short_line) ? HA - 1 : HA,
                 l < 2, (l >= 3) && (l < 3 + n_act));
  endtask

  typedef struct {
    int nlines; int long_line; int short_line; int n_act;
    int exp_err; int exp_locked; int exp_h; int exp_v;
  } row_t;
  row_t rows[19];

  initial begin
    int e0, f0;
    rows[0]  = '{10, -1, -1, 6, 0, 0, 16, 1};
    rows[1]  = '{10, -1, -1, 6, 0, 0, 16, 10};
    rows[2]  = '{10, -1, -1, 6, 0, 1, 16, 10};
    rows[3]  = '{10, -1, -1, 6, 0, 1, 16, 10};
    rows[4]  = '{10,  8, -1, 6, 1, 0, 17, 10};
    rows[5]  = '{10, -1, -1, 6, 0, 0, 16, 10};
    rows[6]  = '{10, -1, -1, 6, 0, 0, 16, 10};
    rows[7]  = '{10, -1, -1, 6, 0, 1, 16, 10};
    rows[8]  = '{10, -1,  5, 6, 1, 0, 16, 10};
    rows[9]  = '{10, -1, -1, 6, 0, 0, 16, 10};
    rows[10] = '{10, -1, -1, 6, 0, 0, 16, 10};
    rows[11] = '{10, -1, -1, 6, 0, 1, 16, 10};
    rows[12] = '{ 9, -1, -1, 6, 0, 1, 16, 10};
    rows[13] = '{10, -1, -1, 6, 1, 0, 16, 9};
    rows[14] = '{10, -1, -1, 6, 0, 0, 16, 10};
    rows[15] = '{10, -1, -1, 6, 0, 0, 16, 10};
    rows[16] = '{10, -1, -1, 6, 0, 1, 16, 10};
    rows[17] = '{10, -1, -1, 7, 1, 0, 16, 10};
    rows[18] = '{10, -1, -1, 6, 0, 0, 16, 10};

    repeat (3) @(posedge clk);
    #1;
    check("rst_pixel_xy", int'(pixel_x) + int'(pixel_y), 0);
    check("rst_meas", int'(h_total_meas) + int'(v_total_meas), 0);
    check("rst_flags", int'({pixel_valid, line_start, frame_start, locked, timing_err}), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 19; i++) begin
      e0 = err_cnt;
      drive_lines(0, rows[i].nlines - 1, rows[i].long_line, rows[i].short_line, rows[i].n_act);
      @(negedge clk);
      check($sformatf("row%0d_err", i), err_cnt - e0, rows[i].exp_err);
      check($sformatf("row%0d_locked", i), int'(locked), rows[i].exp_locked);
      check($sformatf("row%0d_h_meas", i), int'(h_total_meas), rows[i].exp_h);
      check($sformatf("row%0d_v_meas", i), int'(v_total_meas), rows[i].exp_v);
    end
    check("pipeline_table", lat_bad, 0);

    // Full locked frame: one frame_start, one line_start per active line, last pixel corner.
    drive_lines(0, VT - 1, -1, -1, VA);
    f0 = fs_cnt;
    drive_lines(0, VT - 1, -1, -1, VA);
    @(negedge clk);
    check("frame_start_count", fs_cnt - f0, 1);
    check("line_starts_per_frame", ls_in_frame, VA);
    check("last_pixel_x", last_x, HA - 1);
    check("last_pixel_y", last_y, VA - 1);
    check("locked_before_hold", int'(locked), 1);

    // Stuck hsync: h_cnt must saturate and flag exactly once.
    e0 = err_cnt;
    repeat (2000) @(posedge clk);
    @(negedge clk);
    check("hold_no_early_err", err_cnt - e0, 0);
    check("hold_still_locked", int'(locked), 1);
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("hold_err_once", err_cnt - e0, 1);
    check("hold_unlocked", int'(locked), 0);
    drive_lines(0, 0, -1, -1, VA);
    @(negedge clk);
    check("hold_h_meas_sat", int'(h_total_meas), 2047);
    drive_lines(1, VT - 1, -1, -1, VA);

    // Mid-line reset during active video.
    drive_lines(0, 4, -1, -1, VA);
    drive_line(6, HA, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    check("pre_reset_valid", int'(pixel_valid), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_xy", int'(pixel_x) + int'(pixel_y), 0);
    check("async_rst_meas", int'(h_total_meas) + int'(v_total_meas), 0);
    check("async_rst_flags", int'({pixel_valid, line_start, frame_start, locked, timing_err}), 0);
    active = 1'b0; hsync = 1'b1; vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    e0 = err_cnt;
    drive_lines(0, VT - 1, -1, -1, VA);
    drive_lines(0, VT - 1, -1, -1, VA);
    @(negedge clk);
    check("post_rst_not_yet_locked", int'(locked), 0);
    drive_lines(0, VT - 1, -1, -1, VA);
    @(negedge clk);
    check("post_rst_relock", int'(locked), 1);
    check("post_rst_no_err", err_cnt - e0, 0);
    check("post_rst_v_meas", int'(v_total_meas), VT);
    check("pipeline_all", lat_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
